toy_bus_arb2_sched: RTL

TOY_BUS_ARB2_SCHED -- requirements
Module: toy_bus_arb2_sched

---
 rtl/toy_bus_pkg.sv | 42 ++++
 rtl/toy_bus_order_fifo.sv | 70 +++++++
 rtl/toy_bus_arb2_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/toy_bus_pkg.sv
// Shared toy_bus definitions: payload widths, field placement inside the
// packed request/ack payloads, and the encoding used to name a requester port.
package toy_bus_pkg;

  // Common field widths
  localparam int ADDR_W = 32;
  localparam int STRB_W = 32;
  localparam int DATA_W = 256;
  localparam int OPC_W  = 1;
  localparam int ID_W   = 4;
  localparam int SB_W   = 10;

  // Request payload {addr, strb, data, opcode, src_id, tgt_id, sideband}
  localparam int REQ_PLD_W    = ADDR_W + STRB_W + DATA_W + OPC_W + 2 * ID_W + SB_W;
  localparam int REQ_SB_LSB   = 0;
  localparam int REQ_TGT_LSB  = REQ_SB_LSB + SB_W;
  localparam int REQ_SRC_LSB  = REQ_TGT_LSB + ID_W;
  localparam int REQ_OPC_LSB  = REQ_SRC_LSB + ID_W;
  localparam int REQ_DATA_LSB = REQ_OPC_LSB + OPC_W;
  localparam int REQ_STRB_LSB = REQ_DATA_LSB + DATA_W;
  localparam int REQ_ADDR_LSB = REQ_STRB_LSB + STRB_W;

  // Ack payload {opcode, data, sideband, src_id, tgt_id}
  localparam int ACK_PLD_W    = OPC_W + DATA_W + SB_W + 2 * ID_W;
  localparam int ACK_TGT_LSB  = 0;
  localparam int ACK_SRC_LSB  = ACK_TGT_LSB + ID_W;
  localparam int ACK_SB_LSB   = ACK_SRC_LSB + ID_W;
  localparam int ACK_DATA_LSB = ACK_SB_LSB + SB_W;
  localparam int ACK_OPC_LSB  = ACK_DATA_LSB + DATA_W;

  // Requester port index, also the value stored in the order FIFO
  typedef enum logic {
    PORT_IN0 = 1'b0,
    PORT_IN1 = 1'b1
  } port_idx_e;

  // The port that gets priority after the given port wins a handshake
  function automatic port_idx_e otherPort(input port_idx_e p);
    return (p == PORT_IN0) ? PORT_IN1 : PORT_IN0;
  endfunction

endpackage

// File: rtl/toy_bus_order_fifo.sv
// Small order FIFO remembering which requester owns each outstanding
// transaction, so acks return to the port that issued the request.
module toy_bus_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];

  // Qualify push/pop against full/empty and compute the next pointers and count
  always_comb begin
    doPush  = push_i & ~full_o;
    doPop   = pop_i & ~empty_o;
    wrPtr_d = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = doPop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!doPush && doPop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on each accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/toy_bus_arb2_sched.sv
// Two-requester round-robin arbiter onto one downstream port. Grants are
// combinational; a stalled grant is locked to its winner, and the order FIFO
// steers each returning ack back to the requester that owns it.
module toy_bus_arb2_sched
  import toy_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REQ_W = REQ_PLD_W,
  parameter int ACK_W = ACK_PLD_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_req_vld,
  output logic             in0_req_rdy,
  input  logic [REQ_W-1:0] in0_req_pld,
  input  logic             in1_req_vld,
  output logic             in1_req_rdy,
  input  logic [REQ_W-1:0] in1_req_pld,
  output logic             out0_req_vld,
  input  logic             out0_req_rdy,
  output logic [REQ_W-1:0] out0_req_pld,
  input  logic             out0_ack_vld,
  output logic             out0_ack_rdy,
  input  logic [ACK_W-1:0] out0_ack_pld,
  output logic             in0_ack_vld,
  input  logic             in0_ack_rdy,
  output logic [ACK_W-1:0] in0_ack_pld,
  output logic             in1_ack_vld,
  input  logic             in1_ack_rdy,
  output logic [ACK_W-1:0] in1_ack_pld,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             err_unexp_ack
);

  port_idx_e rrPtr_q, rrPtr_d;
  port_idx_e lockIdx_q, lockIdx_d;
  logic      lock_q, lock_d;
  logic      errUnexpAck_q, errUnexpAck_d;
  port_idx_e winner;
  port_idx_e ackHead;
  logic      lockedVld;
  logic      reqHs;
  logic      ackHs;
  logic      fifoFull;
  logic      fifoEmpty;
  logic      headData;

  // Pick the winner: a locked stalled grant first, then the only valid
  // requester, otherwise whoever the round-robin pointer favours
  always_comb begin
    lockedVld = (lockIdx_q == PORT_IN0) ? in0_req_vld : in1_req_vld;
    winner    = rrPtr_q;
    if (lock_q && lockedVld) begin
      winner = lockIdx_q;
    end else if (in0_req_vld && !in1_req_vld) begin
      winner = PORT_IN0;
    end else if (in1_req_vld && !in0_req_vld) begin
      winner = PORT_IN1;
    end
  end

  // Request path: forward the winner, hold everything off while full or in reset
  always_comb begin
    out0_req_vld = (in0_req_vld | in1_req_vld) & ~fifoFull & rst_n;
    out0_req_pld = (winner == PORT_IN1) ? in1_req_pld : in0_req_pld;
    in0_req_rdy  = out0_req_rdy & ~fifoFull & rst_n & (winner == PORT_IN0);
    in1_req_rdy  = out0_req_rdy & ~fifoFull & rst_n & (winner == PORT_IN1);
    reqHs        = out0_req_vld & out0_req_rdy;
  end

  // Ack path: route to the FIFO head owner; nothing is accepted while empty
  always_comb begin
    ackHead      = port_idx_e'(headData);
    in0_ack_vld  = out0_ack_vld & ~fifoEmpty & (ackHead == PORT_IN0);
    in1_ack_vld  = out0_ack_vld & ~fifoEmpty & (ackHead == PORT_IN1);
    out0_ack_rdy = ~fifoEmpty & ((ackHead == PORT_IN0) ? in0_ack_rdy : in1_ack_rdy);
    in0_ack_pld  = out0_ack_pld;
    in1_ack_pld  = out0_ack_pld;
    ackHs        = out0_ack_vld & out0_ack_rdy;
  end

  // Next-state for priority pointer, grant lock and sticky error flag
  always_comb begin
    rrPtr_d       = reqHs ? otherPort(winner) : rrPtr_q;
    lock_d        = out0_req_vld & ~out0_req_rdy;
    lockIdx_d     = winner;
    errUnexpAck_d = errUnexpAck_q | (out0_ack_vld & fifoEmpty);
  end

  // Arbitration state registers; reset gives in0 priority and clears the lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q       <= PORT_IN0;
      lock_q        <= 1'b0;
      lockIdx_q     <= PORT_IN0;
      errUnexpAck_q <= 1'b0;
    end else begin
      rrPtr_q       <= rrPtr_d;
      lock_q        <= lock_d;
      lockIdx_q     <= lockIdx_d;
      errUnexpAck_q <= errUnexpAck_d;
    end
  end

  assign err_unexp_ack = errUnexpAck_q;

  toy_bus_order_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) uOrderFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (reqHs),
    .pushData_i (winner),
    .pop_i      (ackHs),
    .popData_o  (headData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (outstanding_cnt)
  );

endmodule
